// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: bundles the link-layer message stream and the shared unit bus
// of the command decoder.
//   msg_data/msg_valid/msg_end -> decoder, msg_ready <- decoder   (link side)
//   cmd/cmd_ready/arg_data/proto_error/cmd_timeout <- decoder     (unit side)
//   arg_advance/cmd_done -> decoder                              (unit side)
// Modports: slave = the decoder, master = link layer + units.
interface cmd_decoder_if #(
   parameter int CMD_BITS = 6
);
   logic [7:0]          msg_data;
   logic                msg_valid;
   logic                msg_end;
   logic                msg_ready;
   logic [CMD_BITS-1:0] cmd;
   logic                cmd_ready;
   logic [31:0]         arg_data;
   logic                arg_advance;
   logic                cmd_done;
   logic                proto_error;
   logic                cmd_timeout;

   modport slave (
      input  msg_data, msg_valid, msg_end, arg_advance, cmd_done,
      output msg_ready, cmd, cmd_ready, arg_data, proto_error, cmd_timeout
   );

   modport master (
      output msg_data, msg_valid, msg_end, arg_advance, cmd_done,
      input  msg_ready, cmd, cmd_ready, arg_data, proto_error, cmd_timeout
   );
endinterface

// File: rtl/cmd_decoder.sv
// cmd_decoder: decodes VLQ-encoded message fields into a command id plus an
// argument buffer, then dispatches the command on the unit bus until cmd_done.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      cmd_decoder_if.slave (message stream in, command/argument bus out)
// Optional feature: define CMD_DECODER_TIMEOUT_EN to build the dispatch
// watchdog (TIMEOUT_CYCLES); otherwise cmd_timeout is tied low and dispatch
// waits for cmd_done indefinitely.
module cmd_decoder #(
   parameter int CMD_BITS       = 6,
   parameter int MAX_ARGS       = 8,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic         i_clk,
   input  logic         i_reset,
   cmd_decoder_if.slave bus
);
   localparam int AW  = $clog2(MAX_ARGS);      // argument buffer index
   localparam int NFW = $clog2(MAX_ARGS + 2);  // fields seen: id + MAX_ARGS + overflow
   localparam int RPW = $clog2(MAX_ARGS + 1);  // nargs / rd_ptr, 0..MAX_ARGS

   typedef enum logic {S_COLLECT, S_DISPATCH} state_t;

   state_t              r_state;
   logic [24:0]         r_acc;       // only the low 25 bits can still be shifted up
   logic [2:0]          r_nbytes;    // bytes taken so far in the current field
   logic [NFW-1:0]      r_nfields;   // completed fields in the current message
   logic                r_err;
   logic [CMD_BITS-1:0] r_id;        // staged id, latched into r_cmd on dispatch
   logic [CMD_BITS-1:0] r_cmd;
   logic [RPW-1:0]      r_nargs;
   logic [RPW-1:0]      r_rd_ptr;
   logic                r_proto_err;
   logic [31:0]         r_args [MAX_ARGS];

   logic                w_accept;
   logic                w_sext;
   logic [31:0]         w_val;
   logic                w_fdone;
   logic                w_err;
   logic [NFW-1:0]      w_nf;
   logic                w_arg_we;

`ifdef CMD_DECODER_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TOW-1:0]      r_to_cnt;
   logic                r_cmd_to;
`endif

   assign w_accept = bus.msg_valid & (r_state == S_COLLECT);

   // Field decode for the byte on the bus; error state includes this byte.
   always_comb begin
      w_sext  = (r_nbytes == 3'd0) & bus.msg_data[6] & bus.msg_data[5];
      w_val   = (r_nbytes == 3'd0) ? {{25{w_sext}}, bus.msg_data[6:0]}
                                   : {r_acc, bus.msg_data[6:0]};
      w_fdone = ~bus.msg_data[7];
      w_err   = r_err;
      w_nf    = r_nfields;
      // a sixth byte in one field means the field overflowed 5 bytes
      if (r_nbytes == 3'd5) w_err = 1'b1;
      if (!w_err && w_fdone) begin
         if (r_nfields == '0) begin
            if (|w_val[31:CMD_BITS]) w_err = 1'b1;
         end else if (r_nfields > NFW'(MAX_ARGS)) begin
            w_err = 1'b1;
         end
         if (!w_err) w_nf = r_nfields + NFW'(1);
      end
   end

   assign w_arg_we = w_accept & ~w_err & w_fdone & (r_nfields != '0);

   // Argument storage needs no reset: reads are gated by nargs.
   always_ff @(posedge i_clk) begin
      if (w_arg_we) r_args[AW'(r_nfields - NFW'(1))] <= w_val;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_COLLECT;
         r_acc       <= '0;
         r_nbytes    <= '0;
         r_nfields   <= '0;
         r_err       <= 1'b0;
         r_id        <= '0;
         r_cmd       <= '0;
         r_nargs     <= '0;
         r_rd_ptr    <= '0;
         r_proto_err <= 1'b0;
`ifdef CMD_DECODER_TIMEOUT_EN
         r_to_cnt    <= '0;
         r_cmd_to    <= 1'b0;
`endif
      end else begin
         r_proto_err <= 1'b0;
`ifdef CMD_DECODER_TIMEOUT_EN
         r_cmd_to    <= 1'b0;
`endif
         case (r_state)
            S_COLLECT: begin
               if (bus.msg_valid) begin
                  r_err <= w_err;
                  // once in error, swallow bytes without decoding until msg_end
                  if (!w_err) begin
                     r_acc    <= w_val[24:0];
                     r_nbytes <= w_fdone ? 3'd0 : r_nbytes + 3'd1;
                     if (w_fdone) begin
                        r_nfields <= w_nf;
                        if (r_nfields == '0) r_id <= w_val[CMD_BITS-1:0];
                     end
                  end
                  if (bus.msg_end) begin
                     r_acc     <= '0;
                     r_nbytes  <= '0;
                     r_nfields <= '0;
                     r_err     <= 1'b0;
                     // w_fdone here also implies at least one complete field
                     if (!w_err && w_fdone) begin
                        r_cmd    <= (r_nfields == '0) ? w_val[CMD_BITS-1:0] : r_id;
                        r_nargs  <= RPW'(w_nf - NFW'(1));
                        r_rd_ptr <= '0;
                        r_state  <= S_DISPATCH;
`ifdef CMD_DECODER_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                     end else begin
                        r_proto_err <= 1'b1;
                     end
                  end
               end
            end
            S_DISPATCH: begin
               if (bus.arg_advance && (r_rd_ptr != r_nargs))
                  r_rd_ptr <= r_rd_ptr + RPW'(1);
`ifdef CMD_DECODER_TIMEOUT_EN
               if (bus.cmd_done) begin
                  r_state <= S_COLLECT;
               end else if (r_to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                  r_state  <= S_COLLECT;
                  r_cmd_to <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + TOW'(1);
               end
`else
               if (bus.cmd_done) r_state <= S_COLLECT;
`endif
            end
            default: r_state <= S_COLLECT;
         endcase
      end
   end

   assign bus.msg_ready   = (r_state == S_COLLECT);
   // combinational so the finishing unit never sees cmd_ready in its done cycle
   assign bus.cmd_ready   = (r_state == S_DISPATCH) & ~bus.cmd_done;
   assign bus.cmd         = r_cmd;
   assign bus.arg_data    = (r_rd_ptr < r_nargs) ? r_args[AW'(r_rd_ptr)] : 32'd0;
   assign bus.proto_error = r_proto_err;
`ifdef CMD_DECODER_TIMEOUT_EN
   assign bus.cmd_timeout = r_cmd_to;
`else
   assign bus.cmd_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed vectors against cmd_decoder with hand-computed
// expected values; immediate assertions at each comparison point.
module tb_cmd_decoder;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] m[$];

   cmd_decoder_if #(.CMD_BITS(6)) bus ();

   cmd_decoder #(.CMD_BITS(6), .MAX_ARGS(8), .TIMEOUT_CYCLES(16)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change on the falling edge; checks run 1 time unit later
   task automatic idle();
      @(negedge clk);
      bus.msg_valid = 1'b0;
      bus.msg_end   = 1'b0;
      bus.msg_data  = 8'h00;
      #1;
   endtask

   task automatic send_bytes();
      for (int i = 0; i < m.size(); i++) begin
         @(negedge clk);
         bus.msg_valid = 1'b1;
         bus.msg_data  = m[i];
         bus.msg_end   = (i == m.size() - 1);
      end
   endtask

   // sends m, then lands in the first cycle after the msg_end edge
   task automatic send_msg();
      send_bytes();
      idle();
   endtask

   task automatic done_pulse(input string tag);
      @(negedge clk);
      bus.cmd_done = 1'b1;
      #1;
      chk({tag, "_rdy_in_done"}, bus.cmd_ready, 0);
      @(negedge clk);
      bus.cmd_done = 1'b0;
      #1;
      chk({tag, "_msg_ready_after"}, bus.msg_ready, 1);
   endtask

   initial begin
      bus.msg_valid   = 1'b0;
      bus.msg_end     = 1'b0;
      bus.msg_data    = 8'h00;
      bus.arg_advance = 1'b1;
      bus.cmd_done    = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_msg_ready", bus.msg_ready, 1);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_cmd", bus.cmd, 0);
      chk("rst_arg_data", bus.arg_data, 0);
      chk("rst_proto_error", bus.proto_error, 0);
      chk("rst_cmd_timeout", bus.cmd_timeout, 0);
      reset = 1'b0;

      // 05 03 81 00, advance held high: args stream 3, 128, then 0
      m = '{8'h05, 8'h03, 8'h81, 8'h00};
      send_msg();
      chk("t1_cmd_ready", bus.cmd_ready, 1);
      chk("t1_msg_ready", bus.msg_ready, 0);
      chk("t1_cmd", bus.cmd, 5);
      chk("t1_arg0", bus.arg_data, 32'd3);
      idle();
      chk("t1_arg1", bus.arg_data, 32'd128);
      idle();
      chk("t1_arg_end", bus.arg_data, 32'd0);
      chk("t1_still_ready", bus.cmd_ready, 1);
      done_pulse("t1");

      // 02 7f: sign-extended -1, held without cmd_done
      bus.arg_advance = 1'b0;
      m = '{8'h02, 8'h7f};
      send_msg();
      chk("t2_cmd", bus.cmd, 2);
      chk("t2_arg0", bus.arg_data, 32'hffffffff);
      for (int i = 0; i < 10; i++) begin
         idle();
         chk("t2_hold_cmd_ready", bus.cmd_ready, 1);
         chk("t2_hold_msg_ready", bus.msg_ready, 0);
      end
      chk("t2_arg_held", bus.arg_data, 32'hffffffff);
      done_pulse("t2");

      // 01 81 with msg_end on a continuation byte: dropped
      m = '{8'h01, 8'h81};
      send_msg();
      chk("t3_proto_error", bus.proto_error, 1);
      chk("t3_no_cmd_ready", bus.cmd_ready, 0);
      idle();
      chk("t3_proto_pulse_end", bus.proto_error, 0);
      chk("t3_no_cmd_ready2", bus.cmd_ready, 0);
      chk("t3_msg_ready", bus.msg_ready, 1);
      m = '{8'h07, 8'h2a};
      send_msg();
      chk("t3_next_cmd_ready", bus.cmd_ready, 1);
      chk("t3_next_cmd", bus.cmd, 7);
      chk("t3_next_arg0", bus.arg_data, 32'h2a);
      done_pulse("t3");

      // nine argument fields: one too many
      m = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
      send_msg();
      chk("t4_overflow_err", bus.proto_error, 1);
      chk("t4_overflow_no_rdy", bus.cmd_ready, 0);

      // eight argument fields: all streamed, ninth read returns 0
      bus.arg_advance = 1'b1;
      m = '{8'h03, 8'h0a, 8'h0b, 8'h0c, 8'h0d, 8'h0e, 8'h0f, 8'h10, 8'h11};
      send_msg();
      chk("t4_full_cmd_ready", bus.cmd_ready, 1);
      chk("t4_full_cmd", bus.cmd, 3);
      for (int i = 0; i < 8; i++) begin
         chk("t4_full_arg", bus.arg_data, 32'h0a + i);
         idle();
      end
      chk("t4_ninth_read", bus.arg_data, 0);
      done_pulse("t4");

      // max id 63, 0x60 sign extension, 5-byte field, 0x40 as an argument
      m = '{8'h3f, 8'h60, 8'h8f, 8'hff, 8'hff, 8'hff, 8'h7f, 8'h40};
      send_msg();
      chk("t5_cmd_max", bus.cmd, 6'h3f);
      chk("t5_sext_60", bus.arg_data, 32'hffffffe0);
      idle();
      chk("t5_five_byte", bus.arg_data, 32'hffffffff);
      idle();
      chk("t5_no_sext_40", bus.arg_data, 32'h40);
      idle();
      chk("t5_tail", bus.arg_data, 0);
      done_pulse("t5");

      // id 64 does not fit in 6 bits
      m = '{8'h40, 8'h01};
      send_msg();
      chk("t6_id_range_err", bus.proto_error, 1);
      chk("t6_id_range_no_rdy", bus.cmd_ready, 0);

      // six-byte field
      m = '{8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};
      send_msg();
      chk("t6_long_field_err", bus.proto_error, 1);
      chk("t6_long_field_no_rdy", bus.cmd_ready, 0);

      // cmd_done in the first dispatch cycle, next message right behind it
      m = '{8'h09};
      send_bytes();
      @(negedge clk);
      bus.msg_valid = 1'b0;
      bus.msg_end   = 1'b0;
      bus.cmd_done  = 1'b1;
      #1;
      chk("t7_rdy_low_in_done", bus.cmd_ready, 0);
      chk("t7_cmd", bus.cmd, 9);
      @(negedge clk);
      bus.cmd_done  = 1'b0;
      bus.msg_valid = 1'b1;
      bus.msg_data  = 8'h0b;
      bus.msg_end   = 1'b0;
      #1;
      chk("t7_accept_next", bus.msg_ready, 1);
      m = '{8'h05};
      send_msg();
      chk("t7_b2b_cmd", bus.cmd, 6'h0b);
      chk("t7_b2b_arg", bus.arg_data, 32'd5);

      // reset during dispatch
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("t8_rst_cmd_ready", bus.cmd_ready, 0);
      chk("t8_rst_msg_ready", bus.msg_ready, 1);
      chk("t8_rst_cmd", bus.cmd, 0);
      reset = 1'b0;

      // reset mid-message discards the partial message
      m = '{8'h01};
      @(negedge clk);
      bus.msg_valid = 1'b1;
      bus.msg_data  = 8'h01;
      bus.msg_end   = 1'b0;
      @(negedge clk);
      bus.msg_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m = '{8'h06};
      send_msg();
      chk("t9_cmd_after_rst", bus.cmd, 6);
      chk("t9_no_args", bus.arg_data, 0);
      chk("t9_ready", bus.cmd_ready, 1);
      done_pulse("t9");

`ifdef CMD_DECODER_TIMEOUT_EN
      m = '{8'h0c};
      send_msg();
      for (int i = 0; i < 15; i++) begin
         chk("t10_no_timeout_yet", bus.cmd_timeout, 0);
         idle();
      end
      chk("t10_no_timeout_16", bus.cmd_timeout, 0);
      idle();
      chk("t10_timeout_pulse", bus.cmd_timeout, 1);
      chk("t10_msg_ready", bus.msg_ready, 1);
      idle();
      chk("t10_timeout_end", bus.cmd_timeout, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
